// File: rtl/rgb_pattern_gen_pkg.sv
// Shared definitions for the RGB pattern generator.
// Holds the video timing constants shared with the sync generator.
// Holds the pattern mode encodings, the colour-bar table and the bouncing-box limits.
// Helper functions:
//   bar_index - which colour bar an x coordinate falls in.
package rgb_pattern_gen_pkg;

  localparam int H_ACTIVE  = 200;
  localparam int V_ACTIVE  = 160;
  localparam int H_TOTAL   = 261;
  localparam int V_TOTAL   = 168;
  localparam int BAR_W     = 25;
  localparam int BOX_SIZE  = 16;
  localparam int BOX_X_MAX = H_ACTIVE - BOX_SIZE;  // 184
  localparam int BOX_Y_MAX = V_ACTIVE - BOX_SIZE;  // 144

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COLOR_WHITE   = 24'hFFFFFF;
  localparam rgb_t COLOR_YELLOW  = 24'hFFFF00;
  localparam rgb_t COLOR_CYAN    = 24'h00FFFF;
  localparam rgb_t COLOR_GREEN   = 24'h00FF00;
  localparam rgb_t COLOR_MAGENTA = 24'hFF00FF;
  localparam rgb_t COLOR_RED     = 24'hFF0000;
  localparam rgb_t COLOR_BLUE    = 24'h0000FF;
  localparam rgb_t COLOR_BLACK   = 24'h000000;
  localparam rgb_t COLOR_BOX_BG  = 24'h000080;

  // Packed so that element 0 (the leftmost bar) is the last item listed.
  localparam logic [7:0][23:0] BAR_COLORS = {
    COLOR_BLACK, COLOR_BLUE, COLOR_RED, COLOR_MAGENTA,
    COLOR_GREEN, COLOR_CYAN, COLOR_YELLOW, COLOR_WHITE
  };

  // h / BAR_W for the active range, built from seven threshold compares
  // so no divider is synthesised.
  function automatic logic [2:0] bar_index(input logic [10:0] h);
    logic [2:0] idx;
    idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h >= 11'(k * BAR_W)) idx = idx + 3'd1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rgb_pattern_gen_if.sv
// Pixel bus between the timing/sync stage and the RGB pattern generator.
//   pix_en, h_count, v_count           : coordinates from the timing counter
//   red, green, blue, pix_valid,
//   frame_start                        : registered pixel back to the sync stage
// master = timing/sync side, slave = pattern generator.
interface rgb_pattern_gen_if;
  logic        pix_en;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        pix_valid;
  logic        frame_start;

  modport master (
    output pix_en, h_count, v_count,
    input  red, green, blue, pix_valid, frame_start
  );

  modport slave (
    input  pix_en, h_count, v_count,
    output red, green, blue, pix_valid, frame_start
  );
endinterface

// File: rtl/rgb_pattern_gen_box_mover.sv
// Bouncing-box position tracker.
// Moves the box one pixel per axis each time update is high, and reverses direction at the edges.
// Ports:
//   clk, rst - clock, synchronous active-high reset (box to (0,0), moving +x/+y)
//   update   - one-cycle strobe at the frame boundary
//   bx, by   - top-left corner of the box
module rgb_pattern_gen_box_mover
  import rgb_pattern_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  output logic [7:0] bx,
  output logic [7:0] by
);

  logic [7:0] pos [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam logic [7:0] MAX = (gi == 0) ? 8'(BOX_X_MAX) : 8'(BOX_Y_MAX);

    logic [7:0] pos_q, pos_d;
    logic       neg_q, neg_d;  // 1 = moving towards 0

    // At an edge the direction flips and the same update already steps
    // back inwards, so the box never rests two frames on the edge.
    always_comb begin
      pos_d = pos_q;
      neg_d = neg_q;
      if (update) begin
        if (!neg_q) begin
          if (pos_q >= MAX) begin
            neg_d = 1'b1;
            pos_d = pos_q - 8'd1;
          end else begin
            pos_d = pos_q + 8'd1;
          end
        end else begin
          if (pos_q == 8'd0) begin
            neg_d = 1'b0;
            pos_d = pos_q + 8'd1;
          end else begin
            pos_d = pos_q - 8'd1;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pos_q <= '0;
        neg_q <= 1'b0;
      end else begin
        pos_q <= pos_d;
        neg_q <= neg_d;
      end
    end

    assign pos[gi] = pos_q;
  end

  assign bx = pos[0];
  assign by = pos[1];

endmodule

// File: rtl/rgb_pattern_gen.sv
// RGB test-pattern generator.
// Turns the timing counter coordinates into 8-bit-per-channel RGB with one pix_en cycle of latency.
// Patterns: colour bars, checker, gradient, bouncing box.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   mode_sel  - requested pattern (0 bars, 1 checker, 2 gradient, 3 box)
//   mode_load - strobe capturing mode_sel as the pending mode
//   pix       - pixel bus (slave): coordinates in, registered RGB out
// A pending mode only takes effect at the last pixel of a frame, so a frame is never drawn in two patterns.
module rgb_pattern_gen
  import rgb_pattern_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_sel,
  input  logic             mode_load,
  rgb_pattern_gen_if.slave pix
);

  mode_e active_q, active_d;
  mode_e pending_q, pending_d;
  rgb_t  rgb_q, rgb_d;
  logic  valid_q, valid_d;
  logic  fs_q, fs_d;

  logic        boundary;
  logic        in_active;
  logic        in_box;
  logic [7:0]  bx, by;
  logic [10:0] bx_w;
  logic [9:0]  by_w;

  assign boundary = pix.pix_en
                 && (pix.h_count == 11'(H_TOTAL - 1))
                 && (pix.v_count == 10'(V_TOTAL - 1));

  rgb_pattern_gen_box_mover u_box (
    .clk    (clk),
    .rst    (rst),
    .update (boundary),
    .bx     (bx),
    .by     (by)
  );

  assign bx_w = {3'b000, bx};
  assign by_w = {2'b00, by};

  always_comb begin
    // A strobe on the boundary cycle itself goes straight to active.
    pending_d = mode_load ? mode_e'(mode_sel) : pending_q;
    active_d  = boundary ? pending_d : active_q;

    in_active = (pix.h_count < 11'(H_ACTIVE)) && (pix.v_count < 10'(V_ACTIVE));
    in_box    = (pix.h_count >= bx_w) && (pix.h_count < bx_w + 11'(BOX_SIZE))
             && (pix.v_count >= by_w) && (pix.v_count < by_w + 10'(BOX_SIZE));

    rgb_d   = COLOR_BLACK;
    valid_d = in_active;
    fs_d    = (pix.h_count == 11'd0) && (pix.v_count == 10'd0);

    if (in_active) begin
      case (active_q)
        MODE_BARS:  rgb_d = BAR_COLORS[bar_index(pix.h_count)];
        MODE_CHECK: rgb_d = (pix.h_count[3] ^ pix.v_count[3]) ? COLOR_WHITE : COLOR_BLACK;
        MODE_GRAD:  rgb_d = '{r: pix.h_count[7:0],
                              g: pix.v_count[7:0],
                              b: pix.h_count[7:0] + pix.v_count[7:0]};
        MODE_BOX:   rgb_d = in_box ? COLOR_WHITE : COLOR_BOX_BG;
        default:    rgb_d = COLOR_BLACK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= MODE_BARS;
      pending_q <= MODE_BARS;
      rgb_q     <= COLOR_BLACK;
      valid_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      if (pix.pix_en) begin
        rgb_q   <= rgb_d;
        valid_q <= valid_d;
        fs_q    <= fs_d;
      end
    end
  end

  assign pix.red         = rgb_q.r;
  assign pix.green       = rgb_q.g;
  assign pix.blue        = rgb_q.b;
  assign pix.pix_valid   = valid_q;
  assign pix.frame_start = fs_q;

endmodule
